// File: rtl/cbfp_mag_buffer.sv
// Ping-pong 16-sample block buffer that tags each complex sample with its CBFP magnitude index.
// Define CBFP_BLK_MIN_EN to build a per-bank running minimum presented on blk_min.
module cbfp_mag_buffer #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned MAG_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_re,
  input  logic signed [IN_WIDTH-1:0]  in_im,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [IN_WIDTH-1:0]  out_re  [15:0],
  output logic signed [IN_WIDTH-1:0]  out_im  [15:0],
  output logic        [MAG_WIDTH-1:0] mag_out [15:0],
  output logic        [MAG_WIDTH-1:0] blk_min
);

  if ((2 ** MAG_WIDTH) <= (IN_WIDTH - 1)) begin : gen_width_check
    $error("MAG_WIDTH cannot represent every magnitude index of IN_WIDTH");
  end

  // Redundant sign bits below the MSB: leading bits equal to the sign, minus one.
  function automatic logic [MAG_WIDTH-1:0] comp_idx(input logic [IN_WIDTH-1:0] x);
    logic [MAG_WIDTH-1:0] n;
    logic                 done;
    n    = '0;
    done = 1'b0;
    for (int i = int'(IN_WIDTH) - 2; i >= 0; i--) begin
      if (!done && (x[i] == x[IN_WIDTH-1])) begin
        n = n + MAG_WIDTH'(1);
      end else begin
        done = 1'b1;
      end
    end
    return n;
  endfunction

  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [3:0] wr_idx_q, wr_idx_d;

  logic signed [IN_WIDTH-1:0]  mem_re  [2][16];
  logic signed [IN_WIDTH-1:0]  mem_im  [2][16];
  logic        [MAG_WIDTH-1:0] mem_mag [2][16];

  logic                 accept;
  logic                 release_blk;
  logic [MAG_WIDTH-1:0] re_idx, im_idx, s_idx;

  assign in_ready    = ~full_q[wr_bank_q];
  assign out_valid   = full_q[rd_bank_q];
  assign accept      = in_valid & in_ready;
  assign release_blk = out_valid & out_ready;

  assign re_idx = comp_idx(in_re);
  assign im_idx = comp_idx(in_im);
  assign s_idx  = (re_idx < im_idx) ? re_idx : im_idx;

  // Release and fill always target different banks, so both may land on one edge.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    if (release_blk) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (accept) begin
      wr_idx_d = wr_idx_q + 4'd1;
      if (wr_idx_q == 4'd15) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= 4'd0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  // Sample storage needs no reset: it is only visible through the out_valid gate.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re[wr_bank_q][wr_idx_q]  <= in_re;
      mem_im[wr_bank_q][wr_idx_q]  <= in_im;
      mem_mag[wr_bank_q][wr_idx_q] <= s_idx;
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      out_re[i]  = out_valid ? mem_re[rd_bank_q][i]  : '0;
      out_im[i]  = out_valid ? mem_im[rd_bank_q][i]  : '0;
      mag_out[i] = out_valid ? mem_mag[rd_bank_q][i] : '0;
    end
  end

`ifdef CBFP_BLK_MIN_EN
  logic [MAG_WIDTH-1:0] bank_min [2];

  always_ff @(posedge clk) begin
    if (accept) begin
      if ((wr_idx_q == 4'd0) || (s_idx < bank_min[wr_bank_q])) begin
        bank_min[wr_bank_q] <= s_idx;
      end
    end
  end

  assign blk_min = out_valid ? bank_min[rd_bank_q] : '0;
`else
  assign blk_min = '0;
`endif

endmodule

// File: tb/tb_cbfp_mag_buffer.sv
// Self-checking bench for cbfp_mag_buffer: a queue of pending samples models the
// two-bank buffer (at most 32 pending, a block is presentable once 16 are pending).
module tb_cbfp_mag_buffer;

  localparam int unsigned IN_WIDTH  = 16;
  localparam int unsigned MAG_WIDTH = 6;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [IN_WIDTH-1:0]  in_re, in_im;
  logic signed [IN_WIDTH-1:0]  out_re  [15:0];
  logic signed [IN_WIDTH-1:0]  out_im  [15:0];
  logic        [MAG_WIDTH-1:0] mag_out [15:0];
  logic        [MAG_WIDTH-1:0] blk_min;

  always #5 clk = ~clk;

  cbfp_mag_buffer #(
    .IN_WIDTH (IN_WIDTH),
    .MAG_WIDTH(MAG_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .mag_out  (mag_out),
    .blk_min  (blk_min)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [IN_WIDTH-1:0] q_re[$];
  logic [IN_WIDTH-1:0] q_im[$];

  // Index = IN_WIDTH-1 minus the bit length of the magnitude-folded value.
  function automatic int comp_idx(input logic [IN_WIDTH-1:0] x);
    logic [IN_WIDTH-1:0] y;
    int bits;
    y = x[IN_WIDTH-1] ? ~x : x;
    bits = 0;
    while ((y >> bits) != 0) bits++;
    return int'(IN_WIDTH) - 1 - bits;
  endfunction

  function automatic int exp_mag(input logic [IN_WIDTH-1:0] re, input logic [IN_WIDTH-1:0] im);
    int a, b;
    a = comp_idx(re);
    b = comp_idx(im);
    return (a < b) ? a : b;
  endfunction

  function automatic int exp_blk_min();
`ifdef CBFP_BLK_MIN_EN
    int m;
    m = 1000;
    for (int i = 0; i < 16; i++) if (exp_mag(q_re[i], q_im[i]) < m) m = exp_mag(q_re[i], q_im[i]);
    return m;
`else
    return 0;
`endif
  endfunction

  function automatic logic [IN_WIDTH-1:0] rnd_sample();
    logic signed [IN_WIDTH-1:0] r;
    r = IN_WIDTH'($urandom);
    r = r >>> $urandom_range(0, IN_WIDTH);
    return r;
  endfunction

  // One clock: handshakes are decided by the model, outputs sampled #1 after the edge.
  task automatic tick(input logic v, input logic [IN_WIDTH-1:0] re,
                      input logic [IN_WIDTH-1:0] im, input logic rdy);
    logic acc, rel;
    in_valid  = v;
    in_re     = re;
    in_im     = im;
    out_ready = rdy;
    acc = v && (q_re.size() < 32);
    rel = rdy && (q_re.size() >= 16);
    @(posedge clk);
    #1;
    if (rel) begin
      repeat (16) begin
        void'(q_re.pop_front());
        void'(q_im.pop_front());
      end
    end
    if (acc) begin
      q_re.push_back(re);
      q_im.push_back(im);
    end
  endtask

  task automatic test_reset();
    int nz;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    nz = 0;
    for (int i = 0; i < 16; i++) if (out_re[i] !== '0 || out_im[i] !== '0 || mag_out[i] !== '0) nz++;
    n_cmp++;
    if (nz != 0 || blk_min !== '0) begin
      n_err++; $display("FAIL rst_outputs: %0d nonzero entries, blk_min=%0d, required all 0", nz, blk_min);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_single_mag();
    int bad;
    for (int k = 0; k < 15; k++) tick(1'b1, 16'h0001, 16'h0000, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mag14_early_valid: got %b, required 0", out_valid); end
    tick(1'b1, 16'h0001, 16'h0000, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL mag14_valid: got %b, required 1", out_valid); end
    bad = 0;
    for (int i = 0; i < 16; i++) if (int'(mag_out[i]) !== 14 || out_re[i] !== 16'sd1) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL mag14_data: %0d entries wrong, mag_out[0]=%0d required 14", bad, mag_out[0]); end
    n_cmp++;
    if (int'(blk_min) !== exp_blk_min()) begin
      n_err++; $display("FAIL mag14_blk_min: got %0d, required %0d", blk_min, exp_blk_min());
    end
    tick(1'b0, '0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mag14_release: out_valid %b, required 0", out_valid); end
  endtask

  task automatic test_outlier();
    int p, bad;
    p = $urandom_range(0, 15);
    for (int k = 0; k < 16; k++) tick(1'b1, (k == p) ? 16'h4000 : 16'h0010, 16'h0000, 1'b0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (int'(mag_out[i]) !== ((i == p) ? 0 : 10)) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL outlier_mag: %0d entries wrong, mag_out[%0d]=%0d required 0", bad, p, mag_out[p]); end
    n_cmp++;
    if (int'(blk_min) !== exp_blk_min()) begin
      n_err++; $display("FAIL outlier_blk_min: got %0d, required %0d", blk_min, exp_blk_min());
    end
    tick(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_backpressure();
    int bad;
    for (int k = 0; k < 32; k++) tick(1'b1, rnd_sample(), rnd_sample(), 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b, required 0", in_ready); end
    for (int k = 0; k < 3; k++) tick(1'b1, rnd_sample(), rnd_sample(), 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_hold: in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
    end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (out_re[i] !== q_re[i] || out_im[i] !== q_im[i] || int'(mag_out[i]) !== exp_mag(q_re[i], q_im[i])) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL bp_block0: %0d of 16 entries differ from model", bad); end
    tick(1'b1, rnd_sample(), rnd_sample(), 1'b1);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_one_release: in_ready=%b out_valid=%b, required 1/1", in_ready, out_valid);
    end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (out_re[i] !== q_re[i] || out_im[i] !== q_im[i] || int'(mag_out[i]) !== exp_mag(q_re[i], q_im[i])) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL bp_block1: %0d of 16 entries differ from model", bad); end
    for (int k = 0; k < 16; k++) tick(1'b1, rnd_sample(), rnd_sample(), 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_refill_ready: got %b, required 0", in_ready); end
    for (int b = 0; b < 2; b++) begin
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (out_re[i] !== q_re[i] || out_im[i] !== q_im[i] || int'(mag_out[i]) !== exp_mag(q_re[i], q_im[i])) bad++;
      n_cmp++;
      if (bad != 0 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_drain%0d: %0d entries differ, out_valid=%b", b, bad, out_valid);
      end
      tick(1'b0, '0, '0, 1'b1);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: out_valid %b, required 0", out_valid); end
  endtask

  task automatic test_simultaneous();
    int bad;
    for (int k = 0; k < 31; k++) tick(1'b1, rnd_sample(), rnd_sample(), 1'b0);
    tick(1'b1, rnd_sample(), rnd_sample(), 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL simul_flags: out_valid=%b in_ready=%b, required 1/1", out_valid, in_ready);
    end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (out_re[i] !== q_re[i] || out_im[i] !== q_im[i] || int'(mag_out[i]) !== exp_mag(q_re[i], q_im[i])) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL simul_bank1: %0d of 16 entries differ from model", bad); end
    tick(1'b0, '0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL simul_drain: out_valid %b, required 0", out_valid); end
  endtask

  task automatic test_midreset();
    int nz, bad;
    for (int k = 0; k < 23; k++) tick(1'b1, rnd_sample(), rnd_sample(), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    nz = 0;
    for (int i = 0; i < 16; i++) if (out_re[i] !== '0 || out_im[i] !== '0 || mag_out[i] !== '0) nz++;
    n_cmp++;
    if (out_valid !== 1'b0 || nz != 0 || blk_min !== '0) begin
      n_err++; $display("FAIL midrst_outputs: out_valid=%b nonzero=%0d blk_min=%0d, required 0", out_valid, nz, blk_min);
    end
    q_re.delete();
    q_im.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 15; k++) tick(1'b1, rnd_sample(), rnd_sample(), 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_early: out_valid %b, required 0", out_valid); end
    tick(1'b1, rnd_sample(), rnd_sample(), 1'b0);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (out_re[i] !== q_re[i] || out_im[i] !== q_im[i] || int'(mag_out[i]) !== exp_mag(q_re[i], q_im[i])) bad++;
    n_cmp++;
    if (bad != 0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL midrst_block: %0d entries differ, out_valid=%b", bad, out_valid);
    end
    tick(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_random();
    int bad;
    logic v, rdy;
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      n_cmp++;
      if (in_ready !== (q_re.size() < 32)) begin
        n_err++; $display("FAIL rnd_in_ready c=%0d: got %b, pending %0d", c, in_ready, q_re.size());
      end
      n_cmp++;
      if (out_valid !== (q_re.size() >= 16)) begin
        n_err++; $display("FAIL rnd_out_valid c=%0d: got %b, pending %0d", c, out_valid, q_re.size());
      end
      if (q_re.size() >= 16) begin
        bad = 0;
        for (int i = 0; i < 16; i++)
          if (out_re[i] !== q_re[i] || out_im[i] !== q_im[i] || int'(mag_out[i]) !== exp_mag(q_re[i], q_im[i])) bad++;
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL rnd_block c=%0d: %0d of 16 entries differ", c, bad); end
        n_cmp++;
        if (int'(blk_min) !== exp_blk_min()) begin
          n_err++; $display("FAIL rnd_blk_min c=%0d: got %0d, required %0d", c, blk_min, exp_blk_min());
        end
      end
      tick(v, rnd_sample(), rnd_sample(), rdy);
    end
  endtask

  initial begin
    test_reset();
    test_single_mag();
    test_outlier();
    test_backpressure();
    test_simultaneous();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cbfp_mag_buffer.md
CBFP_MAG_BUFFER -- requirements
Module: cbfp_mag_buffer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, the signed width of each real and imaginary component.
REQ-002 SHALL have parameter MAG_WIDTH, default 6, the width of each magnitude index; the design SHALL require 2**MAG_WIDTH > IN_WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_re and in_im (input, signed IN_WIDTH each): the sample stream.
REQ-006 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the block handshake.
REQ-007 SHALL have ports out_re[15:0] and out_im[15:0] (output, IN_WIDTH each), holding the 16 buffered samples in arrival order (index 0 = first).
REQ-008 SHALL have port mag_out[15:0] (output, MAG_WIDTH each), the per-sample magnitude index, feeding the downstream minimum comparator tree.
REQ-009 SHALL have port blk_min (output, MAG_WIDTH), the block minimum magnitude index (see REQ-024).

Function
REQ-010 A sample SHALL be accepted on any clock edge with in_valid=1 and in_ready=1.
REQ-011 Component index SHALL be the count of leading bits equal to the sign bit, minus one (range 0..IN_WIDTH-1); 0 and -1 both give IN_WIDTH-1, and 0x7FFF and 0x8000 both give 0 (IN_WIDTH=16).
REQ-012 Sample index SHALL be min(index(re), index(im)), zero-extended to MAG_WIDTH.
REQ-013 Storage SHALL be two banks (ping-pong) of 16 entries each; an entry holds re, im and the sample index, all written in the acceptance cycle.
REQ-014 The write pointer (bank, idx 0..15) SHALL increment on each accepted sample; after idx 15 it wraps to idx 0, the bank is marked FULL, and the write bank toggles.
REQ-015 in_ready SHALL be 1 exactly when the current write bank is not FULL; it is a registered-state function, with no combinational path from in_valid.
REQ-016 out_valid SHALL be 1 exactly when the read bank is FULL; outputs SHALL present that bank, stable while out_valid=1 and out_ready=0.
REQ-017 A block SHALL be released on any edge with out_valid=1 and out_ready=1: the read bank's FULL flag clears and the read bank toggles.
REQ-018 Latency: out_valid SHALL rise on the edge after the 16th sample of a block is accepted, with outputs valid in the same cycle.
REQ-019 Release of bank A and acceptance of the 16th sample into bank B in the same cycle SHALL both take effect: A becomes free and B becomes FULL, with no lost or duplicated block.
REQ-020 With both banks FULL, in_ready SHALL be 0 until a release occurs; in_ready returns to 1 on the edge following that release.
REQ-021 A partial block (idx != 0) SHALL hold its data indefinitely while in_valid=0; there is no timeout and no flush.
REQ-022 Outputs SHALL be fully registered: no combinational path from any input to any output.

Reset
REQ-023 On rst=1, asynchronously: both FULL flags 0, write and read bank 0, idx 0, out_valid 0, in_ready 1 once rst deasserts, and out_re, out_im, mag_out and blk_min all 0. Mid-block reset discards all partial and full blocks.

Configuration
REQ-024 Macro CBFP_BLK_MIN_EN: when defined, each bank SHALL keep a running minimum of its sample indices, updated per accepted sample and initialised to the first sample's index, and blk_min SHALL show the read bank's minimum whenever out_valid=1; when not defined, no running-minimum logic SHALL be built and blk_min SHALL be tied to 0.

Verification
REQ-025 Stream 16 samples re=0x0001, im=0x0000 with out_ready=1 -> out_valid rises one cycle after the 16th accept, all mag_out=14, and blk_min=14 (with the macro).
REQ-026 Block containing one sample re=0x4000 and fifteen samples re=0x0010, im=0 -> that entry's mag_out=0, others 10, blk_min=0 (with the macro) or 0 (without).
REQ-027 Stream 48 samples with out_ready=0 -> in_ready falls after sample 32; raise out_ready for one cycle -> exactly one block released, in_ready=1 on the next edge, the remaining 16 accepted.
REQ-028 Release bank 0 on the same edge as the 16th accept into bank 1 -> the next cycle shows out_valid=1 with bank 1 data, and no gap or duplicate in the scoreboard.
REQ-029 Assert rst after 7 samples of a block -> all outputs 0 and out_valid=0; the next 16 samples form a clean block starting at index 0.
